// File: rtl/fp_add_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : fp_add_sequencer
//  Brief    : Multi-cycle IEEE-754 single-precision adder controller
//             (unpack, align, add, normalize, round), one step per clock.
//  Revision : 1.0 - initial release
// ============================================================================
module fp_add_sequencer #(
   parameter int ALIGN_STEP = 4,
   parameter int STICKY_LIM = 27
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] result,
   output logic        overflow,
   output logic        busy
);
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_UNPACK = 3'd1,
      S_ALIGN  = 3'd2,
      S_ADD    = 3'd3,
      S_NORM   = 3'd4,
      S_ROUND  = 3'd5,
      S_DONE   = 3'd6
   } stateT;

   localparam logic [31:0] c_QNAN = 32'h7FC0_0000;

   stateT       r_state;
   logic [31:0] r_opA, r_opB;
   logic        r_signA, r_signB;
   logic [9:0]  r_exp;
   logic [7:0]  r_diff;
   logic [26:0] r_mantA, r_mantB;   // {mant24, G, R, S}

   // Unpack: order operands by magnitude so the subtraction never goes negative
   logic        w_swap;
   logic [31:0] w_big, w_small;
   logic [7:0]  w_expBig, w_expSmall, w_unpDiff;
   logic [23:0] w_mantBig, w_mantSmall;
   logic        w_nanIn, w_infBig, w_infSmall;

   assign w_swap      = r_opB[30:0] > r_opA[30:0];
   assign w_big       = w_swap ? r_opB : r_opA;
   assign w_small     = w_swap ? r_opA : r_opB;
   assign w_expBig    = (w_big[30:23] == 8'd0) ? 8'd1 : w_big[30:23];
   assign w_expSmall  = (w_small[30:23] == 8'd0) ? 8'd1 : w_small[30:23];
   assign w_unpDiff   = w_expBig - w_expSmall;
   assign w_mantBig   = {|w_big[30:23], w_big[22:0]};
   assign w_mantSmall = {|w_small[30:23], w_small[22:0]};
   assign w_nanIn     = ((r_opA[30:23] == 8'hFF) && (r_opA[22:0] != 23'd0)) ||
                        ((r_opB[30:23] == 8'hFF) && (r_opB[22:0] != 23'd0));
   assign w_infBig    = (w_big[30:23] == 8'hFF);
   assign w_infSmall  = (w_small[30:23] == 8'hFF);

   logic [3:0]  w_shAmt;
   logic [26:0] w_lostMask, w_aligned;

   assign w_shAmt    = (r_diff > 8'(ALIGN_STEP)) ? 4'(ALIGN_STEP) : r_diff[3:0];
   assign w_lostMask = (27'd1 << w_shAmt) - 27'd1;
   assign w_aligned  = (r_mantB >> w_shAmt) | {26'd0, |(r_mantB & w_lostMask)};

   logic [27:0] w_sum;
   logic [26:0] w_sumNorm, w_normShift;

   assign w_sum       = (r_signA == r_signB) ? ({1'b0, r_mantA} + {1'b0, r_mantB})
                                             : ({1'b0, r_mantA} - {1'b0, r_mantB});
   assign w_sumNorm   = w_sum[27] ? {w_sum[27:2], w_sum[1] | w_sum[0]} : w_sum[26:0];
   assign w_normShift = {r_mantA[25:0], 1'b0};

   logic        w_inc;
   logic [24:0] w_rounded;
   logic [9:0]  w_rndExp;
   logic [23:0] w_rndMant;

   assign w_inc     = r_mantA[2] & (r_mantA[1] | r_mantA[0] | r_mantA[3]);
   assign w_rounded = {1'b0, r_mantA[26:3]} + {24'd0, w_inc};
   assign w_rndExp  = w_rounded[24] ? (r_exp + 10'd1) : r_exp;
   assign w_rndMant = w_rounded[24] ? w_rounded[24:1] : w_rounded[23:0];

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state   <= S_IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         result    <= 32'd0;
         overflow  <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_opA    <= a;
                  r_opB    <= b;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  r_state  <= S_UNPACK;
               end
            end
            S_UNPACK: begin
               r_signA <= w_big[31];
               r_signB <= w_small[31];
               r_exp   <= {2'b00, w_expBig};
               r_mantA <= {w_mantBig, 3'b000};
               r_diff  <= w_unpDiff;
               if (w_nanIn || (w_infBig && w_infSmall && (w_big[31] != w_small[31]))) begin
                  result   <= c_QNAN;
                  overflow <= 1'b0;
                  r_state  <= S_DONE;
               end else if (w_infBig) begin
                  result   <= w_big;
                  overflow <= 1'b0;
                  r_state  <= S_DONE;
               end else if (w_unpDiff >= 8'(STICKY_LIM)) begin
                  r_mantB <= {26'd0, |w_mantSmall};
                  r_state <= S_ADD;
               end else begin
                  r_mantB <= {w_mantSmall, 3'b000};
                  r_state <= (w_unpDiff == 8'd0) ? S_ADD : S_ALIGN;
               end
            end
            S_ALIGN: begin
               r_mantB <= w_aligned;
               r_diff  <= r_diff - {4'd0, w_shAmt};
               if (r_diff == {4'd0, w_shAmt})
                  r_state <= S_ADD;
            end
            S_ADD: begin
               if (w_sum == 28'd0) begin
                  result   <= {r_signA & r_signB, 31'd0};
                  overflow <= 1'b0;
                  r_state  <= S_DONE;
               end else begin
                  r_mantA <= w_sumNorm;
                  r_exp   <= w_sum[27] ? (r_exp + 10'd1) : r_exp;
                  // Already normalized (or denormal floor) results skip NORM entirely
                  if (w_sum[27] || w_sum[26] || (r_exp == 10'd1))
                     r_state <= S_ROUND;
                  else
                     r_state <= S_NORM;
               end
            end
            S_NORM: begin
               r_mantA <= w_normShift;
               r_exp   <= r_exp - 10'd1;
               if (w_normShift[26] || (r_exp == 10'd2))
                  r_state <= S_ROUND;
            end
            S_ROUND: begin
               if (w_rndExp >= 10'd255) begin
                  result   <= {r_signA, 8'hFF, 23'd0};
                  overflow <= 1'b1;
               end else begin
                  result   <= {r_signA, (w_rndMant[23] ? w_rndExp[7:0] : 8'd0), w_rndMant[22:0]};
                  overflow <= 1'b0;
               end
               r_state <= S_DONE;
            end
            S_DONE: begin
               if (!out_valid) begin
                  out_valid <= 1'b1;
               end else if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
                  r_state   <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_fp_add_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fp_add_sequencer
//  Brief    : Directed and randomized bench for fp_add_sequencer against an
//             exact-integer IEEE-754 addition model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fp_add_sequencer;
   logic        clk;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        overflow;
   logic        busy;

   int total = 0;
   int bad   = 0;

   fp_add_sequencer #(.ALIGN_STEP(4), .STICKY_LIM(27)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .overflow  (overflow),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, got, want);
      end
   endtask

   // Exact sum as an integer multiple of 2^-149, then rounded to nearest-even
   function automatic logic [31:0] refAdd(input logic [31:0] x, input logic [31:0] y,
                                          output logic ovf);
      logic signed [299:0] ix, iy, s;
      logic [299:0]        mag, q, rem, half;
      logic [23:0]         mx, my;
      int                  ex, ey, p, e, sh;
      logic                sg, xNan, yNan, xInf, yInf;
      ovf  = 1'b0;
      xNan = (x[30:23] == 8'hFF) && (x[22:0] != 0);
      yNan = (y[30:23] == 8'hFF) && (y[22:0] != 0);
      xInf = (x[30:23] == 8'hFF) && (x[22:0] == 0);
      yInf = (y[30:23] == 8'hFF) && (y[22:0] == 0);
      if (xNan || yNan || (xInf && yInf && (x[31] != y[31]))) return 32'h7FC0_0000;
      if (xInf) return x;
      if (yInf) return y;
      mx = {|x[30:23], x[22:0]};
      my = {|y[30:23], y[22:0]};
      ex = (x[30:23] == 0) ? 1 : int'(x[30:23]);
      ey = (y[30:23] == 0) ? 1 : int'(y[30:23]);
      ix = 300'(mx) <<< (ex - 1);
      iy = 300'(my) <<< (ey - 1);
      if (x[31]) ix = -ix;
      if (y[31]) iy = -iy;
      s = ix + iy;
      if (s == 0) return {x[31] & y[31], 31'd0};
      sg  = (s < 0);
      mag = sg ? 300'(-s) : 300'(s);
      p = 0;
      for (int i = 0; i < 300; i++) if (mag[i]) p = i;
      if (p < 23) return {sg, 8'd0, mag[22:0]};
      sh = p - 23;
      e  = p - 22;
      q  = mag >> sh;
      if (sh > 0) begin
         rem  = mag & ((300'd1 << sh) - 300'd1);
         half = 300'd1 << (sh - 1);
         if ((rem > half) || ((rem == half) && q[0])) q = q + 300'd1;
      end
      if (q[24]) begin
         q = q >> 1;
         e++;
      end
      if (e >= 255) begin
         ovf = 1'b1;
         return {sg, 8'hFF, 23'd0};
      end
      return {sg, e[7:0], q[22:0]};
   endfunction

   function automatic logic [31:0] randOp(input int nearExp);
      int          mode, e;
      logic [31:0] v;
      mode = $urandom_range(0, 19);
      v    = {$urandom_range(0, 1) == 1, 8'd0, 23'($urandom)};
      case (mode)
         0:       v[22:0] = 23'd0;
         1:       begin v[30:23] = 8'hFF; v[22:0] = 23'd0; end
         2:       begin v[30:23] = 8'hFF; v[22:0] = 23'($urandom_range(1, 32'h7FFFFF)); end
         3:       v[30:23] = 8'd0;
         4:       v[30:23] = 8'd254;
         19:      v[30:23] = 8'($urandom_range(1, 254));
         default: begin
            e = nearExp + int'($urandom_range(0, 14)) - 7;
            if (e < 1) e = 1;
            if (e > 254) e = 254;
            v[30:23] = e[7:0];
         end
      endcase
      return v;
   endfunction

   // Issue one operation, wait for its result, hold, then retire it
   task automatic runOp(input logic [31:0] opA, input logic [31:0] opB, input int holdCycles,
                        input logic noise, output logic [31:0] res, output logic ovf,
                        output int lat);
      int   n;
      logic sawReady, stable;
      res = 32'd0;
      ovf = 1'b0;
      lat = -1;
      n   = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         checkVal("in_ready_wait", 32'(in_ready), 32'd1);
         return;
      end
      a = opA;
      b = opB;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      checkVal("busy_after_accept", 32'(busy), 32'd1);
      lat = 0;
      sawReady = 1'b0;
      while (!out_valid && lat < 200) begin
         if (noise) begin
            in_valid = 1'b1;
            a = $urandom;
            b = $urandom;
         end
         if (in_ready) sawReady = 1'b1;
         @(negedge clk);
         lat++;
      end
      in_valid = 1'b0;
      checkVal("in_ready_while_busy", 32'(sawReady), 32'd0);
      if (!out_valid) begin
         checkVal("result_timeout", 32'(out_valid), 32'd1);
         return;
      end
      checkVal("ready_valid_exclusive", 32'(in_ready), 32'd0);
      res = result;
      ovf = overflow;
      stable = 1'b1;
      for (int k = 0; k < holdCycles; k++) begin
         @(negedge clk);
         if (result !== res || overflow !== ovf || !out_valid || in_ready) stable = 1'b0;
      end
      if (holdCycles > 0) checkVal("hold_stable", 32'(stable), 32'd1);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checkVal("in_ready_after_accept", 32'(in_ready), 32'd1);
      checkVal("out_valid_cleared", 32'(out_valid), 32'd0);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] res, opA, opB, want;
      logic        ovf, wantOvf, seen;
      int          lat;

      reset_n   = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a = 32'd0;
      b = 32'd0;
      repeat (3) @(negedge clk);
      checkVal("rst_in_ready", 32'(in_ready), 32'd1);
      checkVal("rst_out_valid", 32'(out_valid), 32'd0);
      checkVal("rst_result", result, 32'd0);
      checkVal("rst_overflow", 32'(overflow), 32'd0);
      checkVal("rst_busy", 32'(busy), 32'd0);
      reset_n = 1'b1;
      @(negedge clk);

      runOp(32'h3F80_0000, 32'h3F80_0000, 0, 1'b0, res, ovf, lat);
      checkVal("t1_result", res, 32'h4000_0000);
      checkVal("t1_latency", 32'(lat), 32'd4);
      checkVal("t1_overflow", 32'(ovf), 32'd0);

      runOp(32'h3FC0_0000, 32'hBFA0_0000, 0, 1'b0, res, ovf, lat);
      checkVal("t2_result", res, 32'h3E80_0000);
      checkVal("t2_latency", 32'(lat), 32'd6);

      runOp(32'h3F80_0000, 32'h3080_0000, 0, 1'b0, res, ovf, lat);
      checkVal("t3_result", res, 32'h3F80_0000);
      checkVal("t3_latency", 32'(lat), 32'd4);

      runOp(32'h7F7F_FFFF, 32'h7F7F_FFFF, 0, 1'b0, res, ovf, lat);
      checkVal("t4_result", res, 32'h7F80_0000);
      checkVal("t4_overflow", 32'(ovf), 32'd1);
      runOp(32'h7F80_0000, 32'hFF80_0000, 0, 1'b0, res, ovf, lat);
      checkVal("t4_nan_result", res, 32'h7FC0_0000);
      checkVal("t4_nan_overflow", 32'(ovf), 32'd0);
      checkVal("t4_nan_latency", 32'(lat), 32'd2);

      runOp(32'h3F80_0000, 32'h3E80_0000, 5, 1'b0, res, ovf, lat);
      checkVal("t5_result", res, 32'h3FA0_0000);
      checkVal("t5_latency", 32'(lat), 32'd5);

      // Reset while the smaller operand is still being aligned
      a = 32'h3F80_0000;
      b = 32'h3A80_0000;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      checkVal("t6_out_valid", 32'(out_valid), 32'd0);
      checkVal("t6_result", result, 32'd0);
      checkVal("t6_in_ready", 32'(in_ready), 32'd1);
      checkVal("t6_busy", 32'(busy), 32'd0);
      seen = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      checkVal("t6_no_stale_result", 32'(seen), 32'd0);
      runOp(32'h3F80_0000, 32'hBF80_0000, 0, 1'b0, res, ovf, lat);
      checkVal("t6_new_result", res, 32'h0000_0000);

      for (int i = 0; i < 300; i++) begin
         opA = randOp(int'($urandom_range(1, 254)));
         if ($urandom_range(0, 7) == 0)
            opB = {~opA[31], opA[30:0] ^ 31'($urandom_range(0, 255))};
         else
            opB = randOp(int'(opA[30:23]));
         want = refAdd(opA, opB, wantOvf);
         runOp(opA, opB, int'($urandom_range(0, 3)), $urandom_range(0, 1) == 1, res, ovf, lat);
         checkVal($sformatf("rand%0d_result_%h_%h", i, opA, opB), res, want);
         checkVal($sformatf("rand%0d_overflow", i), 32'(ovf), 32'(wantOvf));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
